door_ctrl_gen2: RTL and testbench



---
 rtl/door_ctrl_gen2_if.sv | 31 +++
 rtl/door_ctrl_gen2.sv | 186 ++++++++++++++++++
 tb/tb_door_ctrl_gen2.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/door_ctrl_gen2_if.sv
// door_ctrl_gen2_if: bundles the door-panel inputs and the motor/status
// outputs of the garage-door controller.
//   Button      raw door button (already synchronised to Clock)
//   UpperLS     upper limit switch, 1 = door fully open
//   LowerLS     lower limit switch, 1 = door fully closed
//   Obstruct    beam sensor, 1 = obstruction in doorway
//   AutoCloseEn 1 = auto-close enabled
//   M           motor command: 00 off, 01 raise, 10 lower
//   State       current state encoding (debug/status)
//   Fault       1 while in FAULT
// master: the panel / environment side. slave: the controller side.
interface door_ctrl_gen2_if;
    logic       Button;
    logic       UpperLS;
    logic       LowerLS;
    logic       Obstruct;
    logic       AutoCloseEn;
    logic [1:0] M;
    logic [2:0] State;
    logic       Fault;

    modport master (
        output Button, UpperLS, LowerLS, Obstruct, AutoCloseEn,
        input  M, State, Fault
    );

    modport slave (
        input  Button, UpperLS, LowerLS, Obstruct, AutoCloseEn,
        output M, State, Fault
    );
endinterface

// File: rtl/door_ctrl_gen2.sv
// door_ctrl_gen2: second-generation garage-door motor controller.
// Debounces and edge-detects the button, auto-reverses on obstruction,
// supports mid-travel stop, auto-closes after a dwell time, and detects
// travel timeouts and limit-switch conflicts (sticky FAULT until Reset).
// After reset the door sits in STOPPED and resyncs from the limit switches.
// Ports:
//   Clock  system clock, rising edge
//   Reset  synchronous, active-high reset
//   bus    door_ctrl_gen2_if.slave (panel inputs, motor/status outputs)
module door_ctrl_gen2 #(
    parameter int DEBOUNCE_CYCLES       = 4,
    parameter int AUTO_CLOSE_CYCLES     = 200,
    parameter int TRAVEL_TIMEOUT_CYCLES = 500
) (
    input  logic             Clock,
    input  logic             Reset,
    door_ctrl_gen2_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_CLOSED   = 3'd0,
        ST_RAISING  = 3'd1,
        ST_OPEN     = 3'd2,
        ST_LOWERING = 3'd3,
        ST_STOPPED  = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DWW = $clog2(AUTO_CLOSE_CYCLES + 1);
    localparam int TTW = $clog2(TRAVEL_TIMEOUT_CYCLES + 1);

    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_PRE  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DWW-1:0] DW_MAX  = DWW'(AUTO_CLOSE_CYCLES);
    localparam logic [TTW-1:0] TT_MAX  = TTW'(TRAVEL_TIMEOUT_CYCLES);

    state_t         state_r;
    state_t         next_state_s;
    logic [1:0]     m_r;
    logic           fault_r;
    logic [DBW-1:0] db_cnt_r;
    logic           btn_ev_r;
    logic [DWW-1:0] dwell_r;
    logic [TTW-1:0] travel_r;
    logic           travel_entry_s;
    logic           open_entry_s;

    // Motor command decoded from a state value.
    function automatic logic [1:0] motor_of(input state_t s);
        case (s)
            ST_RAISING:  motor_of = 2'b01;
            ST_LOWERING: motor_of = 2'b10;
            default:     motor_of = 2'b00;
        endcase
    endfunction

    // Debounce counter and one-shot button event.
    // The event fires on the edge the counter steps into its saturation value,
    // so a held button yields exactly one pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            db_cnt_r <= '0;
            btn_ev_r <= 1'b0;
        end else if (bus.Button) begin
            if (db_cnt_r != DB_MAX) begin
                db_cnt_r <= db_cnt_r + 1'b1;
            end
            btn_ev_r <= (db_cnt_r == DB_PRE);
        end else begin
            db_cnt_r <= '0;
            btn_ev_r <= 1'b0;
        end
    end

    // Next-state logic, branches in priority order.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_CLOSED: begin
                if (btn_ev_r) next_state_s = ST_RAISING;
                else          next_state_s = ST_CLOSED;
            end
            ST_RAISING: begin
                if (bus.UpperLS && bus.LowerLS) next_state_s = ST_FAULT;
                else if (bus.UpperLS)           next_state_s = ST_OPEN;
                else if (btn_ev_r)              next_state_s = ST_STOPPED;
                else if (travel_r == TT_MAX)    next_state_s = ST_FAULT;
                else                            next_state_s = ST_RAISING;
            end
            ST_OPEN: begin
                // A press while obstructed is ignored.
                if (btn_ev_r && !bus.Obstruct)
                    next_state_s = ST_LOWERING;
                else if (bus.AutoCloseEn && !bus.Obstruct && (dwell_r == DW_MAX))
                    next_state_s = ST_LOWERING;
                else
                    next_state_s = ST_OPEN;
            end
            ST_LOWERING: begin
                if (bus.UpperLS && bus.LowerLS) next_state_s = ST_FAULT;
                else if (bus.Obstruct)          next_state_s = ST_RAISING;
                else if (bus.LowerLS)           next_state_s = ST_CLOSED;
                else if (btn_ev_r)              next_state_s = ST_RAISING;
                else if (travel_r == TT_MAX)    next_state_s = ST_FAULT;
                else                            next_state_s = ST_LOWERING;
            end
            ST_STOPPED: begin
                if (bus.LowerLS)      next_state_s = ST_CLOSED;
                else if (bus.UpperLS) next_state_s = ST_OPEN;
                else if (btn_ev_r)    next_state_s = bus.Obstruct ? ST_RAISING : ST_LOWERING;
                else                  next_state_s = ST_STOPPED;
            end
            ST_FAULT: begin
                next_state_s = ST_FAULT;
            end
            default: begin
                // Unused codes recover to a safe, motor-off state.
                next_state_s = ST_STOPPED;
            end
        endcase
    end

    // Entry strobes for the timers; a LOWERING->RAISING reversal counts as entry.
    always_comb begin
        travel_entry_s = 1'b0;
        open_entry_s   = 1'b0;
        if (next_state_s != state_r) begin
            travel_entry_s = (next_state_s == ST_RAISING) || (next_state_s == ST_LOWERING);
            open_entry_s   = (next_state_s == ST_OPEN);
        end else begin
            travel_entry_s = 1'b0;
            open_entry_s   = 1'b0;
        end
    end

    // State register with outputs registered alongside it (Moore decode of next state).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_STOPPED;
            m_r     <= 2'b00;
            fault_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            m_r     <= motor_of(next_state_s);
            fault_r <= (next_state_s == ST_FAULT);
        end
    end

    // Travel timer: restarts on entry to a travel state, saturates at the timeout.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            travel_r <= '0;
        end else if (travel_entry_s) begin
            travel_r <= '0;
        end else if (((state_r == ST_RAISING) || (state_r == ST_LOWERING)) && (travel_r != TT_MAX)) begin
            travel_r <= travel_r + 1'b1;
        end else begin
            travel_r <= travel_r;
        end
    end

    // Dwell timer: held at zero while obstructed or auto-close disabled in OPEN.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            dwell_r <= '0;
        end else if (open_entry_s) begin
            dwell_r <= '0;
        end else if (state_r == ST_OPEN) begin
            if (bus.Obstruct || !bus.AutoCloseEn) begin
                dwell_r <= '0;
            end else if (dwell_r != DW_MAX) begin
                dwell_r <= dwell_r + 1'b1;
            end else begin
                dwell_r <= dwell_r;
            end
        end else begin
            dwell_r <= dwell_r;
        end
    end

    assign bus.M     = m_r;
    assign bus.State = state_r;
    assign bus.Fault = fault_r;

endmodule

// File: tb/tb_door_ctrl_gen2.sv
// Directed bench for door_ctrl_gen2. Each cycle the expected state (and the
// M/Fault values it implies) is pushed to a scoreboard before the clock edge
// and popped/compared just after it.
module tb_door_ctrl_gen2;

    localparam int D = 4;
    localparam int A = 200;
    localparam int T = 500;

    localparam logic [2:0] S_CLOSED   = 3'd0;
    localparam logic [2:0] S_RAISING  = 3'd1;
    localparam logic [2:0] S_OPEN     = 3'd2;
    localparam logic [2:0] S_LOWERING = 3'd3;
    localparam logic [2:0] S_STOPPED  = 3'd4;
    localparam logic [2:0] S_FAULT    = 3'd5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    door_ctrl_gen2_if dif();

    door_ctrl_gen2 #(
        .DEBOUNCE_CYCLES      (D),
        .AUTO_CLOSE_CYCLES    (A),
        .TRAVEL_TIMEOUT_CYCLES(T)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (dif)
    );

    typedef struct {
        logic [2:0] st;
        logic [1:0] m;
        logic       f;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic exp_t mk(input logic [2:0] st, input string tag);
        exp_t e;
        e.st  = st;
        e.m   = (st == S_RAISING) ? 2'b01 : ((st == S_LOWERING) ? 2'b10 : 2'b00);
        e.f   = (st == S_FAULT);
        e.tag = tag;
        return e;
    endfunction

    // One clock: queue the expectation, advance, then compare just after the edge.
    task automatic cyc(input logic [2:0] st, input string tag);
        exp_t e;
        sb.push_back(mk(st, tag));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (dif.State === e.st) else begin
            errors++;
            $error("FAIL %s State observed %0d expected %0d", e.tag, dif.State, e.st);
        end
        checks++;
        assert (dif.M === e.m) else begin
            errors++;
            $error("FAIL %s M observed %b expected %b", e.tag, dif.M, e.m);
        end
        checks++;
        assert (dif.Fault === e.f) else begin
            errors++;
            $error("FAIL %s Fault observed %b expected %b", e.tag, dif.Fault, e.f);
        end
    endtask

    // Debounced press: D edges in cur, event edge moves to nxt, then release.
    task automatic press(input logic [2:0] cur, input logic [2:0] nxt, input string tag);
        dif.Button = 1'b1;
        repeat (D) cyc(cur, tag);
        cyc(nxt, tag);
        dif.Button = 1'b0;
        cyc(nxt, tag);
    endtask

    initial begin
        rst             = 1'b1;
        dif.Button      = 1'b0;
        dif.UpperLS     = 1'b0;
        dif.LowerLS     = 1'b1;
        dif.Obstruct    = 1'b0;
        dif.AutoCloseEn = 1'b0;

        // Reset, then resync to CLOSED from the lower limit switch.
        repeat (3) cyc(S_STOPPED, "reset");
        rst = 1'b0;
        cyc(S_CLOSED, "resync_closed");

        // Debounced press raises after edge D+1; holding does nothing more.
        dif.Button  = 1'b1;
        dif.LowerLS = 1'b0;
        repeat (D) cyc(S_CLOSED, "debounce");
        cyc(S_RAISING, "press_raise");
        repeat (20) cyc(S_RAISING, "hold_button");
        dif.Button  = 1'b0;
        dif.UpperLS = 1'b1;
        cyc(S_OPEN, "upper_ls_open");

        // Auto-close disabled: stays open.
        repeat (1000) cyc(S_OPEN, "ace_off");

        // Dwell to 150, obstruct 10 cycles, then full dwell again.
        dif.AutoCloseEn = 1'b1;
        repeat (150) cyc(S_OPEN, "dwell_run");
        dif.Obstruct = 1'b1;
        repeat (10) cyc(S_OPEN, "obs_hold");
        dif.Obstruct = 1'b0;
        repeat (A) cyc(S_OPEN, "dwell_restart");
        cyc(S_LOWERING, "auto_close");

        // Auto-reverse, then timeout measured from the reversal.
        dif.UpperLS     = 1'b0;
        dif.AutoCloseEn = 1'b0;
        repeat (5) cyc(S_LOWERING, "lowering");
        dif.Obstruct = 1'b1;
        cyc(S_RAISING, "auto_reverse");
        dif.Obstruct = 1'b0;
        repeat (T) cyc(S_RAISING, "travel_restart");
        cyc(S_FAULT, "timeout_fault");

        // FAULT is sticky and ignores the button.
        dif.Button = 1'b1;
        repeat (D + 3) cyc(S_FAULT, "fault_sticky");
        dif.Button = 1'b0;
        cyc(S_FAULT, "fault_sticky");
        rst = 1'b1;
        cyc(S_STOPPED, "fault_reset");
        rst = 1'b0;
        cyc(S_STOPPED, "stopped_idle");

        // STOPPED press without obstruction lowers; Obstruct beats LowerLS.
        press(S_STOPPED, S_LOWERING, "stop_press_lower");
        dif.Obstruct = 1'b1;
        dif.LowerLS  = 1'b1;
        cyc(S_RAISING, "obs_beats_lls");
        dif.Obstruct = 1'b0;
        dif.LowerLS  = 1'b0;
        repeat (3) cyc(S_RAISING, "raising");

        // Mid-travel stop and button-driven reversals.
        press(S_RAISING, S_STOPPED, "mid_stop");
        press(S_STOPPED, S_LOWERING, "press_lower");
        press(S_LOWERING, S_RAISING, "lower_press_rev");
        press(S_RAISING, S_STOPPED, "mid_stop2");
        dif.Obstruct = 1'b1;
        press(S_STOPPED, S_RAISING, "obs_press_raise");
        dif.Obstruct = 1'b0;

        // Limit-switch conflict while lowering.
        press(S_RAISING, S_STOPPED, "mid_stop3");
        press(S_STOPPED, S_LOWERING, "press_lower2");
        dif.UpperLS = 1'b1;
        dif.LowerLS = 1'b1;
        cyc(S_FAULT, "ls_conflict");
        cyc(S_FAULT, "ls_conflict_hold");
        rst = 1'b1;
        cyc(S_STOPPED, "reset2");
        rst = 1'b0;
        dif.UpperLS = 1'b0;
        cyc(S_CLOSED, "resync_closed2");

        // UpperLS outranks a simultaneous button event in RAISING.
        dif.LowerLS = 1'b0;
        press(S_CLOSED, S_RAISING, "raise_again");
        dif.Button = 1'b1;
        repeat (D) cyc(S_RAISING, "uls_btn_debounce");
        dif.UpperLS = 1'b1;
        cyc(S_OPEN, "uls_beats_btn");
        dif.Button = 1'b0;
        cyc(S_OPEN, "open_idle");

        // Press while obstructed in OPEN is ignored.
        dif.Obstruct = 1'b1;
        dif.Button   = 1'b1;
        repeat (D + 3) cyc(S_OPEN, "btn_ignored_obs");
        dif.Button   = 1'b0;
        dif.Obstruct = 1'b0;
        cyc(S_OPEN, "open_after_obs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
